// File: rtl/trace_replay_engine.sv
// Trace replay engine: streams addresses from a synchronous trace memory
// into a cache front end one blocking access at a time, with hit/miss stats.
module trace_replay_engine #(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 19,
    parameter int CNT_W  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              loop_en,
    input  logic [IDX_W:0]    trace_len,
    output logic [IDX_W-1:0]  mem_raddr,
    input  logic [ADDR_W-1:0] mem_rdata,
    output logic              req_valid,
    output logic [ADDR_W-1:0] req_addr,
    input  logic              req_ready,
    input  logic              resp_valid,
    input  logic              resp_hit,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  issued_cnt,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt,
    output logic [CNT_W-1:0]  pass_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_ISSUE, S_RESP, S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [IDX_W-1:0] IDX_ONE = 1;
    localparam logic [IDX_W:0]   LEN_ONE = 1;

    state_t             state;
    state_t             state_nx;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W:0]     len_r;
    logic               loop_r;
    logic               abort_pend;
    logic               go;
    logic               xfer;
    logic               rsp;
    logic               last;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_ONE;
    endfunction

    // abort beats start only once a run has finished
    assign go   = (state == S_IDLE && start) ||
                  (state == S_DONE && start && !abort);
    assign xfer = (state == S_ISSUE) && req_ready;
    assign rsp  = (state == S_RESP) && resp_valid;
    assign last = ({1'b0, idx} == len_r - LEN_ONE);

    assign mem_raddr = idx;

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (go)
                    state_nx = (trace_len == '0) ? S_DONE : S_FETCH;
            end
            S_FETCH: state_nx = abort ? S_DONE : S_LOAD;
            S_LOAD:  state_nx = abort ? S_DONE : S_ISSUE;
            S_ISSUE: begin
                if (req_ready)  state_nx = S_RESP;
                else if (abort) state_nx = S_DONE;
            end
            S_RESP: begin
                // an outstanding access is always drained before stopping
                if (resp_valid) begin
                    if (abort || abort_pend || (last && !loop_r))
                        state_nx = S_DONE;
                    else
                        state_nx = S_FETCH;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        req_valid = (state == S_ISSUE);
        busy      = !(state == S_IDLE || state == S_DONE);
        done      = (state == S_DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            idx        <= '0;
            len_r      <= '0;
            loop_r     <= 1'b0;
            abort_pend <= 1'b0;
            req_addr   <= '0;
            issued_cnt <= '0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
            pass_cnt   <= '0;
        end else begin
            if (go) begin
                len_r      <= trace_len;
                loop_r     <= loop_en;
                idx        <= '0;
                abort_pend <= 1'b0;
                issued_cnt <= '0;
                hit_cnt    <= '0;
                miss_cnt   <= '0;
                pass_cnt   <= '0;
            end
            if (state == S_LOAD)
                req_addr <= mem_rdata;
            if (xfer)
                issued_cnt <= sat_inc(issued_cnt);
            if ((xfer || state == S_RESP) && abort)
                abort_pend <= 1'b1;
            if (rsp) begin
                abort_pend <= 1'b0;
                if (resp_hit) hit_cnt  <= sat_inc(hit_cnt);
                else          miss_cnt <= sat_inc(miss_cnt);
                if (last) begin
                    pass_cnt <= sat_inc(pass_cnt);
                    idx      <= '0;
                end else begin
                    idx <= idx + IDX_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_trace_replay_engine.sv
// Randomised scoreboard bench for trace_replay_engine with a wide-counter
// and a 4-bit-counter instance sharing the same stimulus.
module tb_trace_replay_engine;

    localparam int AW = 32;
    localparam int IW = 8;
    localparam int CW = 32;
    localparam int SW = 4;

    logic          clock = 1'b0;
    logic          reset, start, abort, loop_en;
    logic [IW:0]   trace_len;
    logic [IW-1:0] raddr0, raddr1;
    logic [AW-1:0] rdata0, rdata1;
    logic          req_valid0, req_valid1;
    logic [AW-1:0] req_addr0, req_addr1;
    logic          req_ready, resp_valid, resp_hit;
    logic          busy0, done0, busy1, done1;
    logic [CW-1:0] iss0, hit0, mis0, pas0;
    logic [SW-1:0] iss1, hit1, mis1, pas1;
    logic [AW-1:0] mem [0:255];

    int n_vec = 0;
    int n_err = 0;

    logic [AW-1:0] expq [$];
    bit            hitq [$];
    int            m_hs, m_hit, m_miss, m_pass, m_len;
    bit            pending, last_pos_end, prev_stall;
    logic [AW-1:0] prev_addr;

    int unsigned ready_p = 100;
    int unsigned resp_p  = 100;
    int unsigned hit_p   = 50;
    int          stall_n = 0;
    int          wait_cnt;

    trace_replay_engine #(.ADDR_W(AW), .IDX_W(IW), .CNT_W(CW)) dut0 (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .loop_en(loop_en), .trace_len(trace_len),
        .mem_raddr(raddr0), .mem_rdata(rdata0),
        .req_valid(req_valid0), .req_addr(req_addr0),
        .req_ready(req_ready), .resp_valid(resp_valid),
        .resp_hit(resp_hit), .busy(busy0), .done(done0),
        .issued_cnt(iss0), .hit_cnt(hit0),
        .miss_cnt(mis0), .pass_cnt(pas0)
    );

    trace_replay_engine #(.ADDR_W(AW), .IDX_W(IW), .CNT_W(SW)) dut1 (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .loop_en(loop_en), .trace_len(trace_len),
        .mem_raddr(raddr1), .mem_rdata(rdata1),
        .req_valid(req_valid1), .req_addr(req_addr1),
        .req_ready(req_ready), .resp_valid(resp_valid),
        .resp_hit(resp_hit), .busy(busy1), .done(done1),
        .issued_cnt(iss1), .hit_cnt(hit1),
        .miss_cnt(mis1), .pass_cnt(pas1)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        rdata0 <= mem[raddr0];
        rdata1 <= mem[raddr1];
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int sat4(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    // cache model: random ready/response timing, optional forced stall
    initial begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_hit   = 1'b0;
        wait_cnt   = 0;
        forever begin
            @(posedge clock);
            #1;
            if (req_valid0) wait_cnt++;
            else            wait_cnt = 0;
            req_ready  = (wait_cnt > stall_n) &&
                         ($urandom_range(99) < ready_p);
            resp_valid = ($urandom_range(99) < resp_p);
            resp_hit   = (hitq.size() > 0) ? hitq[0] :
                         ($urandom_range(99) < hit_p);
        end
    end

    // scoreboard monitor: one access = handshake, then first response
    initial begin
        logic [AW-1:0] exp_a;
        pending    = 1'b0;
        prev_stall = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                pending    = 1'b0;
                prev_stall = 1'b0;
            end else begin
                if (pending && resp_valid) begin
                    pending = 1'b0;
                    if (resp_hit) m_hit++;
                    else          m_miss++;
                    if (last_pos_end) m_pass++;
                    if (hitq.size() > 0) void'(hitq.pop_front());
                end
                if (req_valid0 && prev_stall)
                    check("addr_stable", req_addr0, prev_addr);
                if (req_valid0 && req_ready) begin
                    exp_a = (expq.size() > 0) ? expq.pop_front() : 'x;
                    check("req_addr", req_addr0, exp_a);
                    check("mem_raddr", raddr0, m_hs % m_len);
                    last_pos_end = ((m_hs % m_len) == m_len - 1);
                    m_hs++;
                    pending = 1'b1;
                end
                prev_stall = req_valid0 && !req_ready;
                prev_addr  = req_addr0;
            end
        end
    end

    task automatic model_clear(input int len);
        expq.delete();
        m_hs   = 0;
        m_hit  = 0;
        m_miss = 0;
        m_pass = 0;
        m_len  = len;
    endtask

    task automatic run(input int len, input bit lp, input int ab_hs,
                       input int ab_cyc, input int rs_at,
                       output int first_v, output int busy_n,
                       output int cyc);
        model_clear(len);
        if (len > 0)
            for (int i = 0; i < (lp ? 200 : len); i++)
                expq.push_back(mem[i % len]);
        @(posedge clock);
        #1;
        start     = 1'b1;
        trace_len = (IW+1)'(len);
        loop_en   = lp;
        abort     = 1'b0;
        cyc       = 0;
        first_v   = -1;
        busy_n    = 0;
        do begin
            @(posedge clock);
            #1;
            cyc++;
            start = (cyc == rs_at);
            if (start) trace_len = 1;
            if (req_valid0 && first_v < 0) first_v = cyc;
            if (busy0) busy_n++;
            if ((ab_hs > 0 && m_hs >= ab_hs) ||
                (ab_cyc > 0 && cyc >= ab_cyc))
                abort = 1'b1;
        end while (!done0 && cyc < 3000);
        start = 1'b0;
        abort = 1'b0;
        check("run_done", done0, 1);
        @(negedge clock);
        check("busy_end", busy0, 0);
        check("issued", iss0, m_hs);
        check("hits", hit0, m_hit);
        check("misses", mis0, m_miss);
        check("passes", pas0, m_pass);
        check("issued_s", iss1, sat4(m_hs));
        check("hits_s", hit1, sat4(m_hit));
        check("misses_s", mis1, sat4(m_miss));
        check("passes_s", pas1, sat4(m_pass));
        if (ab_hs == 0 && ab_cyc == 0) begin
            check("queue_drained", expq.size(), 0);
            check("issued_len", iss0, len);
        end
        expq.delete();
        hitq.delete();
    endtask

    initial begin
        int fv, bn, cy, len, ab_hs, ab_cyc;
        bit lp;
        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        loop_en   = 1'b0;
        trace_len = '0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_raddr", raddr0, 0);
        check("rst_valid", req_valid0, 0);
        check("rst_addr", req_addr0, 0);
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_issued", iss0, 0);
        check("rst_hit", hit0, 0);
        check("rst_miss", mis0, 0);
        check("rst_pass", pas0, 0);
        reset = 1'b0;

        // basic three-entry trace, immediate handshakes
        mem[0] = 32'h1000;
        mem[1] = 32'h2000;
        mem[2] = 32'h1000;
        hitq   = '{1'b0, 1'b0, 1'b1};
        run(3, 1'b0, 0, 0, 0, fv, bn, cy);
        check("first_valid", fv, 3);
        check("busy_cycles", bn, 12);
        check("t1_hit", hit0, 1);
        check("t1_miss", mis0, 2);
        check("t1_pass", pas0, 1);

        // stalled ready with response pulses during the stall
        stall_n = 5;
        hitq    = '{1'b0, 1'b0, 1'b1};
        run(3, 1'b0, 0, 0, 0, fv, bn, cy);
        check("t2_issued", iss0, 3);
        check("t2_hit", hit0, 1);
        check("t2_busy", bn, 27);
        stall_n = 0;

        // loop mode, abort while waiting on the 20th response
        run(2, 1'b1, 20, 0, 0, fv, bn, cy);
        check("loop_issued", iss0, 20);
        check("loop_pass", pas0, 10);
        check("loop_issued_s", iss1, 15);

        // zero-length trace
        run(0, 1'b0, 0, 0, 0, fv, bn, cy);
        check("len0_latency", cy, 1);
        check("len0_busy", bn, 0);
        check("len0_valid", fv, -1);

        // abort in LOAD
        run(3, 1'b0, 0, 2, 0, fv, bn, cy);
        check("abload_valid", fv, -1);
        check("abload_issued", iss0, 0);

        // start while busy is ignored
        run(3, 1'b0, 0, 0, 5, fv, bn, cy);

        // saturation of narrow counters
        hit_p = 0;
        run(3, 1'b1, 20, 0, 0, fv, bn, cy);
        check("sat_miss", mis0, 20);
        check("sat_miss_s", mis1, 15);
        check("sat_issued_s", iss1, 15);
        check("sat_pass_s", pas1, 6);
        hit_p = 50;

        // reset while waiting for a response
        resp_p = 0;
        model_clear(3);
        for (int i = 0; i < 3; i++) expq.push_back(mem[i]);
        @(posedge clock);
        #1;
        start     = 1'b1;
        trace_len = 3;
        loop_en   = 1'b0;
        cy        = 0;
        do begin
            @(posedge clock);
            #1;
            start = 1'b0;
            cy++;
        end while (m_hs < 1 && cy < 200);
        check("pre_reset_busy", busy0, 1);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("mid_rst_busy", busy0, 0);
        check("mid_rst_done", done0, 0);
        check("mid_rst_valid", req_valid0, 0);
        check("mid_rst_addr", req_addr0, 0);
        check("mid_rst_raddr", raddr0, 0);
        check("mid_rst_issued", iss0, 0);
        check("mid_rst_miss", mis0, 0);
        reset = 1'b0;
        resp_p = 100;
        expq.delete();

        // randomised runs
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < 8; i++) mem[i] = $urandom;
            len     = int'($urandom_range(6, 1));
            lp      = 1'($urandom_range(1));
            ready_p = $urandom_range(100, 30);
            resp_p  = $urandom_range(100, 30);
            stall_n = int'($urandom_range(2));
            ab_hs   = 0;
            ab_cyc  = 0;
            if (lp) begin
                if ($urandom_range(1) == 1)
                    ab_hs = int'($urandom_range(15, 1));
                else
                    ab_cyc = int'($urandom_range(40, 1));
            end else if ($urandom_range(1) == 1) begin
                ab_cyc = int'($urandom_range(30, 1));
            end
            run(len, lp, ab_hs, ab_cyc, 0, fv, bn, cy);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
